// File: rtl/UART_pkg.sv
// UART slave register map: local word addresses and the STATUS layout.
// Word address is taken from byte address bits [3:2].
package UART_pkg;

    localparam logic [1:0] UART_CTRL_ADDR     = 2'd0;
    localparam logic [1:0] UART_STATUS_ADDR   = 2'd1;
    localparam logic [1:0] UART_DIVISION_ADDR = 2'd2;
    localparam logic [1:0] UART_DATA_ADDR     = 2'd3;

    typedef struct packed {
        logic [29:0] reserved;
        logic        rx_event_flag;
        logic        tx_event_flag;
    } status_reg_t;

endpackage

// File: rtl/uart_tx_scheduler_pkg.sv
// Scheduler state encoding and UART bus address helpers.
// Shared by uart_tx_scheduler and its testbench.
package UART_sched_pkg;

    import UART_pkg::*;

    typedef enum logic [2:0] {
        OFF,
        DIV,
        IDLE,
        DATA,
        POLL,
        CLEAR
    } sched_state_t;

    function automatic logic [31:0] uart_addr(
        input logic [31:0] base,
        input logic [1:0]  word
    );
        return base + {28'd0, word, 2'b00};
    endfunction

    // Write-1-to-clear value: only tx_event_flag, never rx_event_flag.
    function automatic logic [31:0] tx_clear_mask();
        status_reg_t s;
        s = '0;
        s.tx_event_flag = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// System bus link between the scheduler (master) and the UART (slave).
// m_valid/m_address/m_wdata/m_wstrobe out, m_ready/m_rdata back.
interface uart_tx_scheduler_if;

    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_address;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrobe;
    logic [31:0] m_rdata;

    modport master (
        output m_valid,
        output m_address,
        output m_wdata,
        output m_wstrobe,
        input  m_ready,
        input  m_rdata
    );

    modport slave (
        input  m_valid,
        input  m_address,
        input  m_wdata,
        input  m_wstrobe,
        output m_ready,
        output m_rdata
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr.
// Ports: req, ptr in; grant (onehot), grant_idx, grant_valid out.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int W = $clog2(N);

    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!grant_valid && req[j[W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = j[W-1:0];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_REQ byte producers (round-robin).
// Ports: clk, reset (async, active-low), division/start config,
//   req_valid/req_data/req_ready per requester, bus (master modport),
//   busy, grant_id, timeout_err.
// Optional poll watchdog: define UART_SEQ_TIMEOUT_EN.
module uart_tx_scheduler
    import UART_pkg::*;
    import UART_sched_pkg::*;
#(
    parameter int          N_REQ          = 4,
    parameter logic [31:0] UART_BASE      = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              division,
    input  logic                     start,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*8-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    uart_tx_scheduler_if.master      bus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N_REQ);

    sched_state_t state_q, state_d;

    logic [31:0]   div_q;
    logic [7:0]    byte_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] grant_q;

    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic [7:0]       arb_byte;
    logic [IW-1:0]    ptr_next;

    logic        m_valid;
    logic [31:0] m_address;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrobe;

    logic        done;
    logic        take;
    logic        poll_expired;
    status_reg_t status;
    logic        unused_status;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign arb_byte = req_data[{arb_idx, 3'b000} +: 8];
    assign ptr_next = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);

    assign done          = m_valid & bus.m_ready;
    assign status        = status_reg_t'(bus.m_rdata);
    assign unused_status = ^{status.reserved, status.rx_event_flag};

    assign bus.m_valid   = m_valid;
    assign bus.m_address = m_address;
    assign bus.m_wdata   = m_wdata;
    assign bus.m_wstrobe = m_wstrobe;

    assign busy     = (state_q != OFF) && (state_q != IDLE);
    assign grant_id = grant_q;

`ifdef UART_SEQ_TIMEOUT_EN
    logic [31:0] poll_cnt_q;
    logic        tmo_q;
    logic        err_q;
    logic        poll_hit;

    assign poll_hit     = (state_q == POLL) &&
                          (poll_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign poll_expired = tmo_q | poll_hit;
    assign timeout_err  = err_q;

    // Counter idles at zero outside POLL, so each POLL visit starts fresh.
    // Once expired, the read in flight still has to complete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_cnt_q <= '0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
        end else if (state_q != POLL) begin
            poll_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_q + 32'd1;
            if (poll_hit) begin
                tmo_q <= 1'b1;
                err_q <= 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_tmo;

    assign unused_tmo   = 32'(TIMEOUT_CYCLES);
    assign poll_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        m_valid   = 1'b0;
        m_address = '0;
        m_wdata   = '0;
        m_wstrobe = 4'h0;
        req_ready = '0;
        take      = 1'b0;
        unique case (state_q)
            OFF: begin
                if (start) begin
                    state_d = DIV;
                end
            end
            DIV: begin
                m_valid   = 1'b1;
                m_address = uart_addr(UART_BASE, UART_DIVISION_ADDR);
                m_wdata   = div_q;
                m_wstrobe = 4'hF;
                if (done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (start) begin
                    state_d = DIV;
                end else if (arb_valid) begin
                    take      = 1'b1;
                    req_ready = arb_grant;
                    state_d   = DATA;
                end
            end
            DATA: begin
                m_valid   = 1'b1;
                m_address = uart_addr(UART_BASE, UART_DATA_ADDR);
                m_wdata   = {24'd0, byte_q};
                m_wstrobe = 4'h1;
                if (done) begin
                    state_d = POLL;
                end
            end
            POLL: begin
                m_valid   = 1'b1;
                m_address = uart_addr(UART_BASE, UART_STATUS_ADDR);
                if (done) begin
                    if (poll_expired) begin
                        state_d = IDLE;
                    end else if (status.tx_event_flag) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                m_valid   = 1'b1;
                m_address = uart_addr(UART_BASE, UART_STATUS_ADDR);
                m_wdata   = tx_clear_mask();
                m_wstrobe = 4'hF;
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= OFF;
            div_q   <= '0;
            byte_q  <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            if (start && (state_q == OFF || state_q == IDLE)) begin
                div_q <= division;
            end
            if (take) begin
                byte_q  <= arb_byte;
                grant_q <= arb_idx;
                ptr_q   <= ptr_next;
            end
        end
    end

endmodule
